// File: rtl/hamming_decoder_8bit_pipe.sv
// Two-stage pipelined SEC decoder for the 12-bit {data, parity} Hamming code word,
// with saturating statistics counters for corrected and uncorrectable deliveries.
module hamming_decoder_8bit_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       data_out,
    output logic [3:0]       syndrome_out,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0] d_in;
    logic [3:0] p_in;
    logic [3:0] syn_in;
    logic       adv;

    logic       s1_valid;
    logic [7:0] s1_data;
    logic [3:0] s1_syn;

    logic [7:0] flip_mask;
    logic       fix_corr;
    logic       fix_unc;

    assign d_in = code_in[11:4];
    assign p_in = code_in[3:0];

    // d7 is intentionally absent: it is not covered by the code.
    assign syn_in[0] = d_in[0] ^ d_in[1] ^ d_in[3] ^ d_in[4] ^ d_in[6] ^ p_in[0];
    assign syn_in[1] = d_in[0] ^ d_in[2] ^ d_in[3] ^ d_in[5] ^ d_in[6] ^ p_in[1];
    assign syn_in[2] = d_in[1] ^ d_in[2] ^ d_in[3] ^ p_in[2];
    assign syn_in[3] = d_in[4] ^ d_in[5] ^ d_in[6] ^ p_in[3];

    // Both stages move together; a stalled output freezes the whole pipe.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        flip_mask = 8'h00;
        case (s1_syn)
            4'd3:    flip_mask = 8'h01;
            4'd5:    flip_mask = 8'h02;
            4'd6:    flip_mask = 8'h04;
            4'd7:    flip_mask = 8'h08;
            4'd9:    flip_mask = 8'h10;
            4'd10:   flip_mask = 8'h20;
            4'd11:   flip_mask = 8'h40;
            default: flip_mask = 8'h00;
        endcase
    end

    assign fix_unc  = (s1_syn >= 4'd12);
    assign fix_corr = (s1_syn != 4'd0) && !fix_unc;

    // NOTE: registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid          <= 1'b0;
            s1_data           <= 8'h00;
            s1_syn            <= 4'h0;
            out_valid         <= 1'b0;
            data_out          <= 8'h00;
            syndrome_out      <= 4'h0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
        end else if (adv) begin
            s1_valid          <= in_valid;
            s1_data           <= d_in;
            s1_syn            <= syn_in;
            out_valid         <= s1_valid;
            data_out          <= s1_data ^ flip_mask;
            syndrome_out      <= s1_syn;
            err_corrected     <= fix_corr;
            err_uncorrectable <= fix_unc;
        end
    end

    // Counters track delivered words only; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (err_corrected && corr_cnt != CNT_MAX)
                corr_cnt <= corr_cnt + CNT_ONE;
            if (err_uncorrectable && uncorr_cnt != CNT_MAX)
                uncorr_cnt <= uncorr_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hamming_decoder_8bit_pipe.sv
// Self-checking bench for hamming_decoder_8bit_pipe: directed vectors, random words,
// randomized backpressure streaming, counter saturation/clear and mid-stream reset.
module tb_hamming_decoder_8bit_pipe;

    localparam int CW = 2;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [11:0]   code_in = 12'h000;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    data_out;
    logic [3:0]    syndrome_out;
    logic          err_corrected;
    logic          err_uncorrectable;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_corr   = '0;
    logic [CW-1:0] exp_uncorr = '0;

    // Syndrome contributed by each covered data bit d0..d6 (its Hamming column).
    int col[7] = '{3, 5, 6, 7, 9, 10, 11};

    hamming_decoder_8bit_pipe #(.CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .code_in           (code_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .syndrome_out      (syndrome_out),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .clr_cnt           (clr_cnt),
        .corr_cnt          (corr_cnt),
        .uncorr_cnt        (uncorr_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [11:0] code);
        exp_t r;
        int   s;
        r.data = code[11:4];
        s = int'(code[3:0]);
        for (int i = 0; i < 7; i++)
            if (r.data[i]) s = s ^ col[i];
        r.syn  = 4'(s);
        r.corr = 1'b0;
        r.unc  = 1'b0;
        if (s >= 12) begin
            r.unc = 1'b1;
        end else if (s != 0) begin
            r.corr = 1'b1;
            for (int i = 0; i < 7; i++)
                if (col[i] == s) r.data[i] = ~r.data[i];
        end
        return r;
    endfunction

    function automatic logic [11:0] rand_code();
        logic [7:0]  d;
        logic [11:0] w;
        int          nflip;
        d = 8'($urandom);
        w = {d, 4'h0};
        w = {d, model(w).syn};
        nflip = $urandom_range(0, 2);
        for (int k = 0; k < nflip; k++)
            w = w ^ (12'h001 << $urandom_range(0, 11));
        return w;
    endfunction

    function automatic void count_model(input exp_t e, input bit clr);
        if (clr) begin
            exp_corr   = '0;
            exp_uncorr = '0;
        end else begin
            if (e.corr && exp_corr != '1) exp_corr = exp_corr + 1'b1;
            if (e.unc && exp_uncorr != '1) exp_uncorr = exp_uncorr + 1'b1;
        end
    endfunction

    // One word through an otherwise empty pipe with out_ready held high.
    task automatic check_word(input string name, input logic [11:0] code, input bit clr_at_out);
        exp_t e;
        e = model(code);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        code_in   = code;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s latency: out_valid=%b one cycle after accept, want 0", name, out_valid);
        end
        @(negedge clk);
        total++;
        if ({out_valid, data_out, syndrome_out, err_corrected, err_uncorrectable} !== {1'b1, e}) begin
            bad++;
            $display("FAIL %s out: got v=%b d=%h s=%h c=%b u=%b want v=1 d=%h s=%h c=%b u=%b (code %h)",
                     name, out_valid, data_out, syndrome_out, err_corrected, err_uncorrectable,
                     e.data, e.syn, e.corr, e.unc, code);
        end
        clr_cnt = clr_at_out;
        count_model(e, clr_at_out);
        @(negedge clk);
        clr_cnt = 1'b0;
        total++;
        if ({out_valid, corr_cnt, uncorr_cnt} !== {1'b0, exp_corr, exp_uncorr}) begin
            bad++;
            $display("FAIL %s cnt: got v=%b corr=%0d uncorr=%0d want v=0 corr=%0d uncorr=%0d",
                     name, out_valid, corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, in_ready, data_out, syndrome_out, err_corrected, err_uncorrectable, corr_cnt, uncorr_cnt}
            !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0, 1'b0, {CW{1'b0}}, {CW{1'b0}}}) begin
            bad++;
            $display("FAIL reset: got v=%b rdy=%b d=%h s=%h c=%b u=%b cc=%0d uc=%0d want all 0, rdy=1",
                     out_valid, in_ready, data_out, syndrome_out, err_corrected, err_uncorrectable,
                     corr_cnt, uncorr_cnt);
        end
        rst = 1'b0;
        exp_corr   = '0;
        exp_uncorr = '0;
    endtask

    task automatic test_vectors();
        check_word("clean_a5f", 12'hA5F, 1'b0);
        check_word("d2_a1f", 12'hA1F, 1'b0);
        for (int i = 0; i < 7; i++)
            check_word($sformatf("data_bit%0d", i), 12'hA5F ^ (12'h010 << i), 1'b0);
        for (int i = 0; i < 4; i++)
            check_word($sformatf("par_bit%0d", i), 12'hA5F ^ (12'h001 << i), 1'b0);
        check_word("unc_b7f", 12'hB7F, 1'b0);
        check_word("d7_25f", 12'h25F, 1'b0);
    endtask

    task automatic test_random_words();
        for (int i = 0; i < 12; i++)
            check_word($sformatf("rand%0d", i), rand_code(), 1'b0);
    endtask

    task automatic test_counters();
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        count_model('0, 1'b1);
        total++;
        if ({corr_cnt, uncorr_cnt} !== {{CW{1'b0}}, {CW{1'b0}}}) begin
            bad++;
            $display("FAIL clr_idle: got corr=%0d uncorr=%0d want 0 0", corr_cnt, uncorr_cnt);
        end
        for (int i = 0; i < 5; i++)
            check_word($sformatf("corr_sat%0d", i), 12'hA5F ^ (12'h010 << i), 1'b0);
        check_word("unc_pre_clr", 12'hB7F, 1'b0);
        check_word("clr_with_hs", 12'hA1F, 1'b1);
    endtask

    task automatic test_back_to_back();
        localparam int N = 16;
        exp_t        q[$];
        exp_t        e;
        logic [13:0] held;
        bit          stalled = 1'b0;
        int          sent = 0;
        int          got  = 0;
        for (int cyc = 0; cyc < 800 && got < N; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (stalled) begin
                    total++;
                    if ({data_out, syndrome_out, err_corrected, err_uncorrectable} !== held) begin
                        bad++;
                        $display("FAIL stall_hold: got %h want %h", {data_out, syndrome_out, err_corrected, err_uncorrectable}, held);
                    end
                end
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) begin
                    stalled = 1'b0;
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL stream_extra: got d=%h with nothing outstanding, want none", data_out);
                    end else begin
                        e = q.pop_front();
                        got++;
                        count_model(e, 1'b0);
                        if ({data_out, syndrome_out, err_corrected, err_uncorrectable} !== e) begin
                            bad++;
                            $display("FAIL stream_word%0d: got d=%h s=%h c=%b u=%b want d=%h s=%h c=%b u=%b",
                                     got, data_out, syndrome_out, err_corrected, err_uncorrectable,
                                     e.data, e.syn, e.corr, e.unc);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held = {data_out, syndrome_out, err_corrected, err_uncorrectable};
                end
            end else begin
                stalled   = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
            end
            if (sent < N) begin
                in_valid = ($urandom_range(0, 3) != 0);
                code_in  = rand_code();
            end else begin
                in_valid = 1'b0;
            end
            #1;
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL in_ready: got %b want %b (v=%b rdy=%b)", in_ready, !out_valid || out_ready, out_valid, out_ready);
            end
            if (in_valid && in_ready) begin
                q.push_back(model(code_in));
                sent++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != N || q.size() != 0) begin
            bad++;
            $display("FAIL stream_count: got %0d delivered, %0d pending want %0d delivered, 0 pending", got, q.size(), N);
        end
        total++;
        if ({corr_cnt, uncorr_cnt} !== {exp_corr, exp_uncorr}) begin
            bad++;
            $display("FAIL stream_cnt: got corr=%0d uncorr=%0d want %0d %0d", corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
        end
    endtask

    task automatic test_reset_mid();
        check_word("pre_rst_unc", 12'hB7F, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        code_in   = 12'hA1F;
        @(negedge clk);
        code_in = 12'hA5D;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_fill: got out_valid=%b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, corr_cnt, uncorr_cnt} !== {1'b0, {CW{1'b0}}, {CW{1'b0}}}) begin
            bad++;
            $display("FAIL mid_rst: got v=%b corr=%0d uncorr=%0d want 0 0 0", out_valid, corr_cnt, uncorr_cnt);
        end
        count_model('0, 1'b1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL post_rst%0d: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random_words();
        test_counters();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
